// File: rtl/mem_responder.sv
// Word-addressed memory slave with a fixed number of wait states before each access.
// Requests are latched in IDLE, optionally delayed in WAIT, and completed with a one-cycle Ready pulse.
module mem_responder #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 64,
  parameter int WAIT_CYC = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             MemReq,
  input  logic             MemWrite,
  input  logic [WIDTH-1:0] Adr,
  input  logic [WIDTH-1:0] WD,
  output logic [WIDTH-1:0] RD,
  output logic             Ready,
  output logic             Busy,
  output logic             AdrErr
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = (WAIT_CYC == 0) ? 4'd0 : 4'(WAIT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] adr_q, adr_d;
  logic [WIDTH-1:0] wd_q, wd_d;
  logic             wr_q, wr_d;
  logic [WIDTH-1:0] rd_q, rd_d;
  logic             ready_q, ready_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] mem [DEPTH];

  // With zero wait states the commit happens on the sampling edge, so the
  // live request fields are used instead of the not-yet-latched copies.
  logic [WIDTH-1:0] sel_adr;
  logic [WIDTH-1:0] sel_wd;
  logic             sel_wr;
  logic [AW-1:0]    sel_idx;
  logic             hi_err;
  logic             legal;
  logic             commit;
  logic             mem_we;
  logic [WIDTH-1:0] mem_rdata;

  assign sel_adr = (state_q == S_IDLE) ? Adr      : adr_q;
  assign sel_wd  = (state_q == S_IDLE) ? WD       : wd_q;
  assign sel_wr  = (state_q == S_IDLE) ? MemWrite : wr_q;
  assign sel_idx = sel_adr[AW+1:2];

  generate
    if (WIDTH > AW + 2) begin : g_hi
      assign hi_err = |sel_adr[WIDTH-1:AW+2];
    end else begin : g_nohi
      assign hi_err = 1'b0;
    end
  endgenerate

  assign legal     = (sel_adr[1:0] == 2'b00) && !hi_err;
  assign mem_rdata = mem[sel_idx];
  // Gated by RST so a reset held across an edge can never commit a write.
  assign mem_we    = commit && sel_wr && legal && RST;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    wd_d    = wd_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    ready_d = 1'b0;
    err_d   = err_q;
    commit  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (MemReq) begin
          adr_d = Adr;
          wd_d  = WD;
          wr_d  = MemWrite;
          if (WAIT_CYC == 0) begin
            state_d = S_ACCESS;
            commit  = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = S_ACCESS;
          commit  = 1'b1;
        end
      end
      S_ACCESS: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (commit) begin
      ready_d = 1'b1;
      err_d   = !legal;
      if (!legal) begin
        rd_d = '0;
      end else if (!sel_wr) begin
        rd_d = mem_rdata;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      adr_q   <= '0;
      wd_q    <= '0;
      wr_q    <= 1'b0;
      rd_q    <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      wd_q    <= wd_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem[sel_idx] <= sel_wd;
    end
  end

  assign RD     = rd_q;
  assign Ready  = ready_q;
  assign AdrErr = err_q;
  assign Busy   = (state_q != S_IDLE);

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter WIDTH, default 32, data and address width in bits.
REQ-002 Parameter DEPTH, default 64, number of WIDTH-bit words; power of two, at least 2.
REQ-003 Parameter WAIT_CYC, default 2, wait states inserted before each access; range 0 to 15.
REQ-004 CLK  input  1  rising-edge clock; the only clock in the block.
REQ-005 RST  input  1  asynchronous, active-low reset.
REQ-006 MemReq  input  1  request strobe; requester holds it high until Ready.
REQ-007 MemWrite  input  1  1 = write, 0 = read; sampled with MemReq.
REQ-008 Adr  input  WIDTH  byte address; sampled with MemReq.
REQ-009 WD  input  WIDTH  write data; sampled with MemReq.
REQ-010 RD  output  WIDTH  read data, registered; valid while Ready=1.
REQ-011 Ready  output  1  one-cycle completion pulse, registered.
REQ-012 Busy  output  1  high while a transaction is in progress.
REQ-013 AdrErr  output  1  error flag, registered; qualified by Ready.

Function
REQ-014 FSM states: IDLE, WAIT, ACCESS; 4-bit down-counter cnt.
REQ-015 IDLE with MemReq=1 at an edge latches Adr, WD and MemWrite.
REQ-016 On that edge the FSM goes to WAIT and loads cnt=WAIT_CYC-1; if WAIT_CYC=0 it goes directly to ACCESS.
REQ-017 IDLE with MemReq=0 stays in IDLE.
REQ-018 WAIT: cnt!=0 decrements cnt; cnt=0 goes to ACCESS on that edge.
REQ-019 On the edge entering ACCESS, the block decodes the latched address and commits the transaction:
- read: RD is loaded from memory.
- write: memory is written; RD is unchanged.
- Ready is set to 1.
REQ-020 ACCESS always goes to IDLE on the next edge, and Ready clears to 0 on that edge.
REQ-021 Latency: request sampled at edge E0; Ready is high exactly in the cycle after edge E0+WAIT_CYC.
REQ-022 Busy is 1 in WAIT and ACCESS and 0 in IDLE; Busy is combinational from state.
REQ-023 The word index is latched Adr[log2(DEPTH)+1:2].
REQ-024 Misaligned address (Adr[1:0]!=0) or out of range (any Adr bit above log2(DEPTH)+1 set):
- no memory write occurs.
- RD is loaded with 0.
- AdrErr=1 together with Ready.
REQ-025 For a legal access, AdrErr is loaded with 0.
REQ-026 Changes on Adr, WD, MemWrite or MemReq during WAIT or ACCESS are ignored.
REQ-027 If MemReq is still high in the cycle after ACCESS, it is treated as a new request, so Ready pulses are separated by at least one IDLE cycle.
REQ-028 A read issued after a completed write to the same word returns the written data.
REQ-029 RD and AdrErr hold their values between transactions.

Reset
REQ-030 RST=0 forces, immediately and independent of CLK: state=IDLE, cnt=0, RD=0, Ready=0, AdrErr=0, Busy=0.
REQ-031 Memory array contents are not reset and are undefined until written.
REQ-032 Reset asserted during WAIT aborts the transaction: no write is committed and no Ready pulse occurs.
REQ-033 After RST deasserts, the first rising edge samples MemReq in IDLE.

Verification (WAIT_CYC=2, DEPTH=64, WIDTH=32)
REQ-034 Reset pulse, then write Adr=0x08, WD=0x000000A5 -> Busy high for 3 cycles, Ready high exactly one cycle after edge E0+2, AdrErr=0.
REQ-035 Read Adr=0x08 -> RD=0x000000A5 with Ready=1, AdrErr=0; RD stays 0x000000A5 after Ready drops.
REQ-036 Write 0x12345678 to Adr=0x0C, then write 0xFFFFFFFF to Adr=0x0C and drop RST during WAIT, then read 0x0C -> no Ready for the aborted write, outputs 0 during reset, read returns 0x12345678.
REQ-037 Read Adr=0x06 (misaligned), then read Adr=0x100 (out of range) -> each gives Ready=1, AdrErr=1, RD=0; a write to 0x06 leaves word 1 unchanged.
REQ-038 MemReq held high across two reads with Adr changed during WAIT -> first RD matches the originally latched Adr; Ready pulses are 4 cycles apart.
REQ-039 WAIT_CYC=0 build: read request at E0 -> Ready high in the cycle after E0; Busy high for 1 cycle.
